key_bounce_gen: RTL and testbench

- Transmitter-side stimulus for the key/debounce path. On command, it drives one complete active-low key press with mechanical-style bounce on both edges, a programmable hold time, and a settle period.
- Used for in-FPGA loopback: key_o feeds a debouncer's en_i in place of a physical button. Press/release counts at the consumer can then be checked against press_cnt_o.

---
 rtl/key_gen_pkg.sv | 22 ++
 rtl/key_bounce_gen_lfsr16.sv | 18 +
 rtl/key_bounce_gen.sv | 130 +++++++++++++
 tb/tb_key_bounce_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/key_gen_pkg.sv
// Shared types and constants for the key bounce generator.
// Latency: n/a (package only).
// Backpressure: n/a.
package key_gen_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    HOLD,
    RELEASE,
    SETTLE
  } key_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form, taps 16,14,13,11, shifting right.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
  endfunction

endpackage

// File: rtl/key_bounce_gen_lfsr16.sv
// 16-bit Galois LFSR, free-running, advances every cycle.
// Latency: q_o updates one cycle after each edge; seed loaded on reset.
// Backpressure: none, no handshake.
// Ports: clk_i clock, rst_i sync active-high reset, q_o current LFSR state.
module lfsr16
  import key_gen_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [15:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) q_o <= LFSR_SEED;
    else       q_o <= lfsr_step(q_o);
  end

endmodule

// File: rtl/key_bounce_gen.sv
// Generates one active-low key press with bounce on both edges, hold and settle.
// Latency: key_o toggles on the edge that accepts start_i; done_o ends the settle gap.
// Backpressure: start_i accepted only in IDLE outside the done_o cycle; otherwise dropped.
// Ports: clk_i, rst_i (sync, active-high), start_i, hold_i[HOLD_W] ->
//        key_o (1 = released), busy_o, done_o, press_cnt_o[8].
// Build option: KEY_BOUNCE_LFSR_EN selects pseudo-random gaps; default is a fixed gap.
module key_bounce_gen
  import key_gen_pkg::*;
#(
  parameter int BOUNCE_PAIRS = 2,
  parameter int GAP_W        = 3,
  parameter int HOLD_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [HOLD_W-1:0] hold_i,
  output logic              key_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        press_cnt_o
);

  localparam int TOG_W = $clog2(2*BOUNCE_PAIRS + 1);
  localparam logic [TOG_W-1:0] TOG_LOAD = TOG_W'(2*BOUNCE_PAIRS);

  key_state_e        state_q, state_d;
  logic              key_q, key_d;
  logic              done_q, done_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TOG_W-1:0]  tog_q, tog_d;
  // The gap counter holds (gap - 1): a toggle fires on the cycle it reads 0,
  // so a gap of g puts g cycles between consecutive toggles.
  logic [GAP_W-1:0]  gap_load;

`ifdef KEY_BOUNCE_LFSR_EN
  logic [15:0] lfsr_q;

  lfsr16 u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .q_o   (lfsr_q)
  );

  assign gap_load = lfsr_q[GAP_W-1:0];
`else
  assign gap_load = GAP_W'((1 << (GAP_W-1)) - 1);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= 1'b1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      tog_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      tog_q   <= tog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    tog_d   = tog_q;
    case (state_q)
      IDLE: begin
        // done_q marks the last busy cycle; a start there is dropped.
        if (start_i && !done_q) begin
          hold_d  = (hold_i == '0) ? HOLD_W'(1) : hold_i;
          key_d   = 1'b0;
          tog_d   = TOG_LOAD;
          gap_d   = gap_load;
          state_d = PRESS;
        end
      end
      PRESS, RELEASE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          key_d = ~key_q;
          tog_d = tog_q - 1'b1;
          gap_d = gap_load;   // also seeds the settle period after RELEASE
          if (tog_q == TOG_W'(1)) state_d = (state_q == PRESS) ? HOLD : SETTLE;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_W'(1)) begin
          key_d   = 1'b1;
          tog_d   = TOG_LOAD;
          gap_d   = gap_load;
          state_d = RELEASE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      SETTLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_o       = key_q;
  assign done_o      = done_q;
  assign press_cnt_o = cnt_q;
  // The FSM is already in IDLE while done_o is shown, so busy covers that cycle too.
  assign busy_o      = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
module tb_key_bounce_gen;

  localparam int BP     = 2;
  localparam int GAP_W  = 3;
  localparam int HOLD_W = 16;
  localparam int G      = 2 ** (GAP_W - 1);   // fixed gap in the default build
  localparam int NTOG   = 2 * BP + 1;         // toggles per edge

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [HOLD_W-1:0] hold_i = '0;
  logic              key_o, busy_o, done_o;
  logic [7:0]        press_cnt_o;

  key_bounce_gen #(.BOUNCE_PAIRS(BP), .GAP_W(GAP_W), .HOLD_W(HOLD_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .hold_i      (hold_i),
    .key_o       (key_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .press_cnt_o (press_cnt_o)
  );

  always #5 clk = ~clk;

  // Edge index: after posedge n (and until the next one) cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    bit         is_done;
    bit         lvl;
    logic [7:0] cnt;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] exp_cnt = 8'd0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic       prev_key = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a press is a list of timed events derived from the edge rules.
  task automatic model_press(input int t0, input int hold, output int td);
    int h, t_rel;
    ev_t e;
    h = (hold == 0) ? 1 : hold;
    for (int k = 0; k < NTOG; k++) begin
      e.t = t0 + k * G; e.is_done = 1'b0; e.lvl = (k % 2 == 1); e.cnt = 8'd0;
      exp_q.push_back(e);
    end
    t_rel = t0 + (NTOG - 1) * G + h;
    for (int k = 0; k < NTOG; k++) begin
      e.t = t_rel + k * G; e.is_done = 1'b0; e.lvl = (k % 2 == 0); e.cnt = 8'd0;
      exp_q.push_back(e);
    end
    td = t_rel + (NTOG - 1) * G + G;
    exp_cnt = exp_cnt + 8'd1;
    e.t = td; e.is_done = 1'b1; e.lvl = 1'b1; e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic mon_event(input bit is_done);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: done=%0d key=%0d at edge %0d, none expected", is_done, key_o, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.t != cyc || e.is_done != is_done ||
        (!is_done && e.lvl != key_o) ||
        (is_done && (press_cnt_o !== e.cnt || busy_o !== 1'b1))) begin
      n_fail++;
      $display("FAIL event: got done=%0d key=%0d cnt=%0d busy=%0d at edge %0d, expected done=%0d key=%0d cnt=%0d busy=1 at edge %0d",
               is_done, key_o, press_cnt_o, busy_o, cyc, e.is_done, e.lvl, e.cnt, e.t);
    end
  endtask

  // Monitor: reacts to whatever the DUT presents, independent of the driver.
  always @(negedge clk) begin
    if (mon_en) begin
      if (key_o !== prev_key) begin
        mon_event(1'b0);
        prev_key = key_o;
      end
      if (done_o === 1'b1) mon_event(1'b1);
      if (exp_q.size() > 0 && exp_q[0].t < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_event: expected done=%0d key=%0d at edge %0d, not seen by edge %0d",
                 exp_q[0].is_done, exp_q[0].lvl, exp_q[0].t, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Issues one press; optional ignored starts at t0+5 and in the done_o cycle,
  // or one random ignored start somewhere inside the busy window.
  task automatic do_press(input int hold, input bit fixed_ignores, input bit rnd_ignore);
    int t0, td, pa, pb;
    start_i = 1'b1;
    hold_i  = HOLD_W'(hold);
    t0 = cyc + 1;
    model_press(t0, hold, td);
    if (fixed_ignores) begin
      pa = t0 + 5; pb = td + 1;
    end else if (rnd_ignore) begin
      pa = t0 + 1 + $urandom_range(0, td - t0); pb = -1;
    end else begin
      pa = -1; pb = -1;
    end
    step();
    start_i = 1'b0;
    hold_i  = HOLD_W'($urandom_range(0, 65535));
    while (cyc < td + 1) begin
      start_i = (cyc + 1 == pa) || (cyc + 1 == pb);
      step();
    end
    start_i = 1'b0;
    chk("busy_after_done", {31'd0, busy_o}, 32'd0);
    chk("done_one_cycle", {31'd0, done_o}, 32'd0);
    chk("press_cnt", {24'd0, press_cnt_o}, {24'd0, exp_cnt});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, td;
    ev_t e;
    repeat (3) step();
    rst_i = 1'b0;
    prev_key = key_o;
    mon_en = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      chk("idle_outputs", {28'd0, key_o, busy_o, done_o, 1'b0}, {28'd0, 4'b1000});
      chk("idle_cnt", {24'd0, press_cnt_o}, 32'd0);
      step();
    end

    // Directed presses: nominal hold, hold 0 (acts as 1), hold 1, ignored starts.
    do_press(10, 1'b0, 1'b0);
    do_press(0, 1'b0, 1'b0);
    do_press(1, 1'b0, 1'b0);
    do_press(7, 1'b1, 1'b0);

    // Reset during HOLD: key released on the reset edge, no done, count cleared.
    repeat (3) step();
    start_i = 1'b1;
    hold_i  = HOLD_W'(10);
    t0 = cyc + 1;
    model_press(t0, 10, td);
    step();
    start_i = 1'b0;
    while (cyc < t0 + 20) step();
    exp_q.delete();
    e.t = t0 + 21; e.is_done = 1'b0; e.lvl = 1'b1; e.cnt = 8'd0;
    exp_q.push_back(e);
    exp_cnt = 8'd0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_key", {31'd0, key_o}, 32'd1);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_cnt", {24'd0, press_cnt_o}, 32'd0);
    while (cyc < td + 5) step();
    chk("rst_no_done_cnt", {24'd0, press_cnt_o}, 32'd0);

    // 256 presses, mostly back-to-back, random holds and stray starts: count wraps.
    for (int i = 0; i < 256; i++) begin
      do_press($urandom_range(0, 6), 1'b0, ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
    end
    chk("wrap_cnt", {24'd0, press_cnt_o}, {24'd0, exp_cnt});

    repeat (10) step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
